// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM port arbiter.
// The optional round-robin grant is enabled with the SRAM_ARB_RR_EN macro.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } arb_state_t;

    localparam logic PORT_IF  = 1'b0;
    localparam logic PORT_MEM = 1'b1;

    localparam int SRAM_DATA_W = 32;
    localparam int SRAM_BE_W   = 4;

    // Reads enable every byte lane; writes enable only the selected lanes.
    function automatic logic [SRAM_BE_W-1:0] pad_be_n(input logic we,
                                                      input logic [SRAM_BE_W-1:0] sel);
        return we ? ~sel : {SRAM_BE_W{1'b0}};
    endfunction

endpackage

// File: rtl/sram_arb_grant.sv
// Requester selection for the SRAM arbiter: data port first by default,
// alternating on contention when SRAM_ARB_RR_EN is defined.
module sram_arb_grant
    import sram_arb_pkg::*;
(
`ifdef SRAM_ARB_RR_EN
    input  logic clk,
    input  logic rst,
    input  logic take,
`endif
    input  logic if_req,
    input  logic mem_req,
    input  logic mask_en,
    input  logic mask_port,
    output logic grant_valid,
    output logic grant_port
);

    logic if_elig;
    logic mem_elig;

    // The port being acknowledged still holds its request, so it is hidden.
    always_comb begin
        if_elig  = if_req  & ~(mask_en & (mask_port == PORT_IF));
        mem_elig = mem_req & ~(mask_en & (mask_port == PORT_MEM));
    end

`ifdef SRAM_ARB_RR_EN
    logic ptr;

    // Pointer moves to the port that was not just granted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= PORT_MEM;
        end else if (take) begin
            ptr <= ~grant_port;
        end
    end

    // A lone requester wins outright; the pointer only breaks ties.
    always_comb begin
        grant_valid = if_elig | mem_elig;
        if (if_elig && mem_elig) begin
            grant_port = ptr;
        end else if (mem_elig) begin
            grant_port = PORT_MEM;
        end else begin
            grant_port = PORT_IF;
        end
    end
`else
    // Fixed priority, data port first.
    always_comb begin
        grant_valid = if_elig | mem_elig;
        if (mem_elig) begin
            grant_port = PORT_MEM;
        end else begin
            grant_port = PORT_IF;
        end
    end
`endif

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one asynchronous SRAM bank between the instruction and data ports.
// Define SRAM_ARB_RR_EN for alternating grants on contention.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 20
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   if_req,
    input  logic [31:0]            if_addr,
    output logic                   if_ack,
    output logic [SRAM_DATA_W-1:0] if_rdata,
    input  logic                   mem_req,
    input  logic                   mem_we,
    input  logic [31:0]            mem_addr,
    input  logic [SRAM_DATA_W-1:0] mem_wdata,
    input  logic [SRAM_BE_W-1:0]   mem_sel,
    output logic                   mem_ack,
    output logic [SRAM_DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0]      sram_addr,
    input  logic [SRAM_DATA_W-1:0] sram_data_i,
    output logic [SRAM_DATA_W-1:0] sram_data_o,
    output logic                   sram_data_oe,
    output logic [SRAM_BE_W-1:0]   sram_be_n,
    output logic                   sram_ce_n,
    output logic                   sram_oe_n,
    output logic                   sram_we_n
);

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

    arb_state_t           state;
    arb_state_t           state_nxt;
    logic [3:0]           wait_cnt;
    logic [3:0]           wait_cnt_nxt;
    logic                 cur_port;
    logic                 cur_we;
    logic [SRAM_BE_W-1:0] cur_sel;
    logic                 grant_valid;
    logic                 grant_port;
    logic                 take;
    logic                 mask_en;
    logic                 grant_we;
    logic [SRAM_BE_W-1:0] grant_sel;
    logic [ADDR_W-1:0]    grant_addr;
    logic                 eff_we;
    logic [SRAM_BE_W-1:0] eff_sel;
    logic                 active_nxt;
    logic                 capture;
    logic                 unused_addr_bits;

    // Only the word-address bits reach the pads; the rest wrap silently.
    assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                                mem_addr[31:ADDR_W+2], mem_addr[1:0]};

    sram_arb_grant u_grant (
`ifdef SRAM_ARB_RR_EN
        .clk         (clk),
        .rst         (rst),
        .take        (take),
`endif
        .if_req      (if_req),
        .mem_req     (mem_req),
        .mask_en     (mask_en),
        .mask_port   (cur_port),
        .grant_valid (grant_valid),
        .grant_port  (grant_port)
    );

    // Next-state logic; a grant is taken only from IDLE or DONE.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        take         = 1'b0;
        mask_en      = (state == ST_DONE);
        case (state)
            ST_IDLE: begin
                if (grant_valid) begin
                    state_nxt = ST_SETUP;
                    take      = 1'b1;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_nxt    = ST_ACCESS;
                wait_cnt_nxt = 4'd0;
            end
            ST_ACCESS: begin
                if (wait_cnt == WAIT_LAST) begin
                    state_nxt = ST_DONE;
                end else begin
                    wait_cnt_nxt = wait_cnt + 4'd1;
                end
            end
            ST_DONE: begin
                if (grant_valid) begin
                    state_nxt = ST_SETUP;
                    take      = 1'b1;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Granted request fields, and the attributes the pads will see next cycle.
    always_comb begin
        if (grant_port == PORT_MEM) begin
            grant_we   = mem_we;
            grant_sel  = mem_sel;
            grant_addr = mem_addr[ADDR_W+1:2];
        end else begin
            grant_we   = 1'b0;
            grant_sel  = {SRAM_BE_W{1'b1}};
            grant_addr = if_addr[ADDR_W+1:2];
        end
        if (take) begin
            eff_we  = grant_we;
            eff_sel = grant_sel;
        end else begin
            eff_we  = cur_we;
            eff_sel = cur_sel;
        end
        active_nxt = (state_nxt == ST_SETUP) || (state_nxt == ST_ACCESS);
        capture    = (state == ST_ACCESS) && (state_nxt == ST_DONE) && !cur_we;
    end

    // FSM state and the latched transaction attributes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            wait_cnt <= 4'd0;
            cur_port <= PORT_MEM;
            cur_we   <= 1'b0;
            cur_sel  <= {SRAM_BE_W{1'b0}};
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (take) begin
                cur_port <= grant_port;
                cur_we   <= grant_we;
                cur_sel  <= grant_sel;
            end
        end
    end

    // Pad strobes, acks and read data, all registered from next-state values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sram_ce_n    <= 1'b1;
            sram_oe_n    <= 1'b1;
            sram_we_n    <= 1'b1;
            sram_be_n    <= {SRAM_BE_W{1'b0}};
            sram_data_oe <= 1'b0;
            sram_addr    <= {ADDR_W{1'b0}};
            sram_data_o  <= {SRAM_DATA_W{1'b0}};
            if_ack       <= 1'b0;
            mem_ack      <= 1'b0;
            if_rdata     <= {SRAM_DATA_W{1'b0}};
            mem_rdata    <= {SRAM_DATA_W{1'b0}};
        end else begin
            sram_ce_n    <= ~active_nxt;
            sram_oe_n    <= ~(active_nxt & ~eff_we);
            sram_we_n    <= ~((state_nxt == ST_ACCESS) & eff_we);
            sram_data_oe <= active_nxt & eff_we;
            sram_be_n    <= active_nxt ? pad_be_n(eff_we, eff_sel) : {SRAM_BE_W{1'b0}};
            if (take) begin
                sram_addr <= grant_addr;
            end
            if (take && grant_we) begin
                sram_data_o <= mem_wdata;
            end
            if_ack  <= (state_nxt == ST_DONE) && (cur_port == PORT_IF);
            mem_ack <= (state_nxt == ST_DONE) && (cur_port == PORT_MEM);
            if (capture && (cur_port == PORT_IF)) begin
                if_rdata <= sram_data_i;
            end
            if (capture && (cur_port == PORT_MEM)) begin
                mem_rdata <= sram_data_i;
            end
        end
    end

endmodule
